// File: rtl/sdadc_rx_if.sv
// sdadc_rx_if -- bus-side signals between the sigma-delta ADC front end and
// its Wishbone wrapper.
//   cssdadc      wrapper -> block  block select
//   start_rx     wrapper -> block  capture enable (runs while cssdadc && start_rx)
//   sample_ack   wrapper -> block  one-cycle pulse, consumes the held sample
//   sample       block -> wrapper  signed 24-bit sample
//   sample_valid block -> wrapper  sample holds an unconsumed value
//   status       block -> wrapper  [0] running, [1] valid, [2] overrun, [7:3] 0
interface sdadc_rx_if;
   logic        cssdadc;
   logic        start_rx;
   logic        sample_ack;
   logic [23:0] sample;
   logic        sample_valid;
   logic [7:0]  status;

   modport master (
      output cssdadc, start_rx, sample_ack,
      input  sample, sample_valid, status
   );

   modport slave (
      input  cssdadc, start_rx, sample_ack,
      output sample, sample_valid, status
   );
endinterface

// File: rtl/sdadc_rx.sv
// sdadc_rx -- first-order sigma-delta ADC front end.
// Synchronizes the external comparator bit, returns it as the 1-bit feedback
// to the RC integrator, decimates the bitstream with a 2nd-order CIC (ratio
// 2^DECIM_LOG2) and offers signed 24-bit samples through a one-entry holding
// register with valid/ack handshake and a sticky overrun flag.
// Ports:
//   clk    system clock, posedge
//   reset  synchronous active-high reset
//   sdin   comparator output (asynchronous to clk)
//   sdfb   feedback bit to the RC network
//   bus    sdadc_rx_if.slave: select/enable/ack in, sample/valid/status out
module sdadc_rx #(
   parameter int DECIM_LOG2 = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sdin,
   output logic        sdfb,
   sdadc_rx_if.slave   bus
);

   localparam int RW = 2*DECIM_LOG2;   // raw result needs RW+1 bits (0..2^RW)
   localparam int W  = RW + 2;         // integrator / comb width, wraps mod 2^W
   localparam int SH = 24 - RW;        // left-justify into the 24-bit sample

   logic                  s1_q, s1_d, s2_q, s2_d;
   logic                  run_q, run_d;
   logic                  sdfb_q, sdfb_d;
   logic [W-1:0]          i1_q, i1_d, i2_q, i2_d;
   logic [W-1:0]          d1_q, d1_d, d2_q, d2_d, c2_q, c2_d;
   logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
   logic [1:0]            warm_q, warm_d;
   logic                  fmt_pend_q, fmt_pend_d;
   logic [23:0]           sample_q, sample_d;
   logic                  valid_q, valid_d;
   logic                  ovr_q, ovr_d;

   logic                  en, tick, load, sat;
   logic [W-1:0]          c1_new;
   logic [RW-1:0]         vsat;
   logic [23:0]           fmt_sample;

   assign en = bus.cssdadc && bus.start_rx;

   always_comb begin
      s1_d       = sdin;
      s2_d       = s1_q;
      run_d      = en;
      sdfb_d     = 1'b0;
      i1_d       = '0;
      i2_d       = '0;
      d1_d       = '0;
      d2_d       = '0;
      c2_d       = '0;
      cnt_d      = '0;
      warm_d     = '0;
      fmt_pend_d = 1'b0;

      tick   = en && (cnt_q == '1);
      // First comb output is only needed combinationally: it feeds c2 and d2
      // on the same tick, so no separate register is kept for it.
      c1_new = i2_q - d1_q;

      if (en) begin
         sdfb_d = s2_q;
         i1_d   = i1_q + {{(W-1){1'b0}}, s2_q};
         i2_d   = i2_q + i1_q;
         cnt_d  = cnt_q + DECIM_LOG2'(1);
         d1_d   = d1_q;
         d2_d   = d2_q;
         c2_d   = c2_q;
         warm_d = warm_q;
         if (tick) begin
            d1_d       = i2_q;
            d2_d       = c1_new;
            c2_d       = c1_new - d2_q;
            // The first two tick results come from half-filled combs.
            fmt_pend_d = (warm_q == 2'd2);
            if (warm_q != 2'd2) warm_d = warm_q + 2'd1;
         end
      end
   end

   // Format: v = r - 2^(RW-1). Since r is in 0..2^RW, only r == 2^RW can
   // overflow (saturate); otherwise subtracting half-scale in RW bits is just
   // an MSB flip.
   always_comb begin
      sat        = |c2_q[W-1:RW];
      vsat       = sat ? {1'b0, {(RW-1){1'b1}}} : {~c2_q[RW-1], c2_q[RW-2:0]};
      fmt_sample = {{SH{vsat[RW-1]}}, vsat} << SH;
   end

   // A pending result is dropped if the block was disabled in between.
   assign load = fmt_pend_q && en;

   always_comb begin
      sample_d = sample_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      if (load) begin
         sample_d = fmt_sample;
         valid_d  = 1'b1;
         if (valid_q && !bus.sample_ack) ovr_d = 1'b1;
         else if (valid_q)               ovr_d = 1'b0;
      end else if (bus.sample_ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         run_q      <= 1'b0;
         sdfb_q     <= 1'b0;
         i1_q       <= '0;
         i2_q       <= '0;
         d1_q       <= '0;
         d2_q       <= '0;
         c2_q       <= '0;
         cnt_q      <= '0;
         warm_q     <= '0;
         fmt_pend_q <= 1'b0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         run_q      <= run_d;
         sdfb_q     <= sdfb_d;
         i1_q       <= i1_d;
         i2_q       <= i2_d;
         d1_q       <= d1_d;
         d2_q       <= d2_d;
         c2_q       <= c2_d;
         cnt_q      <= cnt_d;
         warm_q     <= warm_d;
         fmt_pend_q <= fmt_pend_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
      end
   end

   assign sdfb             = sdfb_q;
   assign bus.sample       = sample_q;
   assign bus.sample_valid = valid_q;
   assign bus.status       = {5'b0, ovr_q, valid_q, run_q};

endmodule

// File: tb/tb_sdadc_rx.sv
// tb_sdadc_rx -- self-checking bench for sdadc_rx (DECIM_LOG2 = 8 and 4).
// Expected samples come from a direct FIR view of the CIC2: each output is a
// triangular-weighted sum of the last 2D-1 synchronized input bits.
module tb_sdadc_rx;
   localparam int D8 = 256;
   localparam int D4 = 16;

   logic clk = 1'b0;
   logic reset, sdin;
   logic sdfb8, sdfb4;
   sdadc_rx_if bus8 ();
   sdadc_rx_if bus4 ();

   sdadc_rx #(.DECIM_LOG2(8)) dut8 (.clk(clk), .reset(reset), .sdin(sdin), .sdfb(sdfb8), .bus(bus8.slave));
   sdadc_rx #(.DECIM_LOG2(4)) dut4 (.clk(clk), .reset(reset), .sdin(sdin), .sdfb(sdfb4), .bus(bus4.slave));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit sd_hist [0:65535];   // sdin value present before edge number cyc

   task automatic step();
      sd_hist[cyc] = sdin;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus8.cssdadc = 1'b0; bus8.start_rx = 1'b0; bus8.sample_ack = 1'b0;
      bus4.cssdadc = 1'b0; bus4.start_rx = 1'b0; bus4.sample_ack = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic prime(input logic v);
      sdin = v;
      do_reset();
      step(); step();
   endtask

   // Raw CIC2 output for output k (k >= 2) after enable at edge e0: the bit
   // seen by the block in enabled cycle j is sdin from edge e0+j-2.
   function automatic longint model_r(input int L, input int e0, input int k);
      int D = 1 << L;
      int T = k*D - 1;
      longint r = 0;
      for (int u = 1; u < 2*D; u++) begin
         int j = T - 1 - u;
         int w = (u <= D) ? u : 2*D - u;
         if (j >= 0 && sd_hist[e0 + j - 2]) r += longint'(w);
      end
      return r;
   endfunction

   function automatic logic [23:0] model_fmt(input int L, input longint r);
      longint half, v, s;
      half = longint'(1) << (2*L - 1);
      v = r - half;
      if (v > half - 1) v = half - 1;
      s = v * (longint'(1) << (24 - 2*L));
      return s[23:0];
   endfunction

   task automatic test_reset();
      sdin = 1'b1;
      do_reset();
      n_cmp++; if (sdfb8 !== 1'b0) begin n_bad++; $display("FAIL reset_sdfb: got %b want 0", sdfb8); end
      n_cmp++; if (bus8.sample !== 24'h0) begin n_bad++; $display("FAIL reset_sample: got %h want 000000", bus8.sample); end
      n_cmp++; if (bus8.sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus8.sample_valid); end
      n_cmp++; if (bus8.status !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %h want 00", bus8.status); end
      n_cmp++; if (bus4.status !== 8'h00) begin n_bad++; $display("FAIL reset_status4: got %h want 00", bus4.status); end
   endtask

   task automatic test_full_high();
      int e0;
      prime(1'b1);
      e0 = cyc;
      bus8.cssdadc = 1'b1; bus8.start_rx = 1'b1;
      for (int n = 0; n <= 4*D8; n++) begin
         bus8.sample_ack = (n == 3*D8 + 1);
         step();
         if (n == 10) begin
            n_cmp++; if (sdfb8 !== 1'b1) begin n_bad++; $display("FAIL high_sdfb: got %b want 1", sdfb8); end
            n_cmp++; if (bus8.status !== 8'h01) begin n_bad++; $display("FAIL high_running: got %h want 01", bus8.status); end
         end
         if (n == 3*D8-1 || n == 4*D8-1 || n == 3*D8+1) begin
            n_cmp++; if (bus8.sample_valid !== 1'b0) begin n_bad++; $display("FAIL high_valid_low n=%0d: got %b want 0", n, bus8.sample_valid); end
         end
         if (n == 3*D8 || n == 4*D8) begin
            n_cmp++; if (bus8.status !== 8'h03) begin n_bad++; $display("FAIL high_valid n=%0d: status %h want 03", n, bus8.status); end
            n_cmp++; if (bus8.sample !== 24'h7FFF00) begin n_bad++; $display("FAIL high_sample n=%0d: got %h want 7fff00", n, bus8.sample); end
            n_cmp++; if (bus8.sample !== model_fmt(8, model_r(8, e0, n/D8))) begin n_bad++; $display("FAIL high_model n=%0d: got %h want %h", n, bus8.sample, model_fmt(8, model_r(8, e0, n/D8))); end
         end
      end
      bus8.start_rx = 1'b0; bus8.sample_ack = 1'b0;
   endtask

   task automatic test_full_low();
      prime(1'b0);
      bus8.cssdadc = 1'b1; bus8.start_rx = 1'b1;
      for (int n = 0; n <= 6*D8; n++) begin
         bus8.sample_ack = bus8.sample_valid;
         step();
         n_cmp++; if (sdfb8 !== 1'b0) begin n_bad++; $display("FAIL low_sdfb n=%0d: got %b want 0", n, sdfb8); end
         if (n == 3*D8-1) begin
            n_cmp++; if (bus8.sample_valid !== 1'b0) begin n_bad++; $display("FAIL low_warmup: valid %b want 0", bus8.sample_valid); end
         end
         if (n >= 3*D8 && n % D8 == 0) begin
            n_cmp++; if (bus8.sample_valid !== 1'b1 || bus8.sample !== 24'h800000) begin n_bad++; $display("FAIL low_sample n=%0d: valid %b sample %h want 1 800000", n, bus8.sample_valid, bus8.sample); end
         end
      end
      bus8.start_rx = 1'b0; bus8.sample_ack = 1'b0;
   endtask

   task automatic test_midscale();
      int e0, sv;
      logic [23:0] exp_s;
      prime(1'b0);
      e0 = cyc;
      bus8.cssdadc = 1'b1; bus8.start_rx = 1'b1;
      for (int n = 0; n <= 6*D8; n++) begin
         sdin = ~sdin;
         bus8.sample_ack = bus8.sample_valid;
         step();
         n_cmp++; if (sdfb8 !== sd_hist[e0 + n - 2]) begin n_bad++; $display("FAIL mid_sdfb n=%0d: got %b want %b", n, sdfb8, sd_hist[e0 + n - 2]); end
         if (n >= 3*D8 && n % D8 == 0) begin
            exp_s = model_fmt(8, model_r(8, e0, n/D8));
            sv = int'($signed(bus8.sample));
            n_cmp++; if (bus8.sample !== exp_s) begin n_bad++; $display("FAIL mid_model n=%0d: got %h want %h", n, bus8.sample, exp_s); end
            n_cmp++; if (sv > 256 || sv < -256) begin n_bad++; $display("FAIL mid_range n=%0d: got %h want 000000 +-100", n, bus8.sample); end
         end
      end
      bus8.start_rx = 1'b0; bus8.sample_ack = 1'b0;
   endtask

   task automatic test_random();
      int e0, p;
      logic [23:0] exp_s;
      p = int'($urandom_range(10, 90));
      prime(1'($urandom_range(0, 1)));
      e0 = cyc;
      bus8.cssdadc = 1'b1; bus8.start_rx = 1'b1;
      for (int n = 0; n <= 7*D8; n++) begin
         sdin = ($urandom_range(0, 99) < p);
         bus8.sample_ack = bus8.sample_valid;
         step();
         if (n >= 3*D8 && n % D8 == 0) begin
            exp_s = model_fmt(8, model_r(8, e0, n/D8));
            n_cmp++; if (bus8.sample_valid !== 1'b1 || bus8.sample !== exp_s) begin n_bad++; $display("FAIL rand_sample n=%0d p=%0d: valid %b got %h want %h", n, p, bus8.sample_valid, bus8.sample, exp_s); end
         end
      end
      bus8.start_rx = 1'b0; bus8.sample_ack = 1'b0;
   endtask

   task automatic test_overrun();
      prime(1'b1);
      bus8.cssdadc = 1'b1; bus8.start_rx = 1'b1;
      for (int n = 0; n <= 7*D8; n++) begin
         bus8.sample_ack = (n == 4*D8 + 5) || (n == 6*D8);
         step();
         if (n == 3*D8) begin
            n_cmp++; if (bus8.status !== 8'h03) begin n_bad++; $display("FAIL ovr_first: status %h want 03", bus8.status); end
         end
         if (n == 4*D8 || n == 7*D8) begin
            n_cmp++; if (bus8.status !== 8'h07) begin n_bad++; $display("FAIL ovr_set n=%0d: status %h want 07", n, bus8.status); end
         end
         if (n == 4*D8 + 5) begin
            n_cmp++; if (bus8.status !== 8'h01) begin n_bad++; $display("FAIL ovr_ack_clear: status %h want 01", bus8.status); end
         end
         if (n == 5*D8) begin
            n_cmp++; if (bus8.status !== 8'h03) begin n_bad++; $display("FAIL ovr_reload: status %h want 03", bus8.status); end
         end
         if (n == 6*D8) begin
            n_cmp++; if (bus8.status !== 8'h03) begin n_bad++; $display("FAIL ovr_ack_with_load: status %h want 03", bus8.status); end
            n_cmp++; if (bus8.sample !== 24'h7FFF00) begin n_bad++; $display("FAIL ovr_ack_load_sample: got %h want 7fff00", bus8.sample); end
         end
      end
      bus8.start_rx = 1'b0; bus8.sample_ack = 1'b0;
   endtask

   task automatic test_disable_reset();
      int e1;
      prime(1'b1);
      bus8.cssdadc = 1'b1; bus8.start_rx = 1'b1;
      for (int n = 0; n < 3*D8 + 100; n++) step();
      bus8.start_rx = 1'b0;   // cnt is 100 on this edge
      step();
      n_cmp++; if (sdfb8 !== 1'b0) begin n_bad++; $display("FAIL dis_sdfb: got %b want 0", sdfb8); end
      n_cmp++; if (bus8.status !== 8'h02) begin n_bad++; $display("FAIL dis_status: got %h want 02", bus8.status); end
      n_cmp++; if (bus8.sample !== 24'h7FFF00) begin n_bad++; $display("FAIL dis_sample_kept: got %h want 7fff00", bus8.sample); end
      for (int n = 0; n < 20; n++) step();
      n_cmp++; if (bus8.sample_valid !== 1'b1) begin n_bad++; $display("FAIL dis_valid_kept: got %b want 1", bus8.sample_valid); end
      bus8.sample_ack = 1'b1; step(); bus8.sample_ack = 1'b0;
      n_cmp++; if (bus8.status !== 8'h00) begin n_bad++; $display("FAIL dis_ack: status %h want 00", bus8.status); end
      e1 = cyc;
      bus8.start_rx = 1'b1;
      for (int n = 0; n <= 3*D8; n++) begin
         step();
         if (n == 3*D8-1) begin
            n_cmp++; if (bus8.sample_valid !== 1'b0) begin n_bad++; $display("FAIL reen_warmup: valid %b want 0", bus8.sample_valid); end
         end
         if (n == 3*D8) begin
            n_cmp++; if (bus8.sample_valid !== 1'b1 || bus8.sample !== model_fmt(8, model_r(8, e1, 3))) begin n_bad++; $display("FAIL reen_sample: valid %b got %h want %h", bus8.sample_valid, bus8.sample, model_fmt(8, model_r(8, e1, 3))); end
         end
      end
      bus8.sample_ack = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; bus8.sample_ack = 1'b0;
      n_cmp++; if (sdfb8 !== 1'b0 || bus8.sample !== 24'h0 || bus8.sample_valid !== 1'b0 || bus8.status !== 8'h00) begin n_bad++; $display("FAIL midreset: sdfb %b sample %h valid %b status %h want 0 000000 0 00", sdfb8, bus8.sample, bus8.sample_valid, bus8.status); end
      bus8.start_rx = 1'b0;
   endtask

   task automatic test_decim4();
      int e0;
      prime(1'b1);
      e0 = cyc;
      bus4.cssdadc = 1'b1; bus4.start_rx = 1'b1;
      for (int n = 0; n <= 4*D4; n++) begin
         step();
         if (n == 3*D4-1) begin
            n_cmp++; if (bus4.sample_valid !== 1'b0) begin n_bad++; $display("FAIL d4_warmup: valid %b want 0", bus4.sample_valid); end
         end
         if (n == 3*D4) begin
            n_cmp++; if (bus4.sample_valid !== 1'b1 || bus4.sample !== 24'h7F0000) begin n_bad++; $display("FAIL d4_first: valid %b got %h want 1 7f0000", bus4.sample_valid, bus4.sample); end
            n_cmp++; if (bus4.sample !== model_fmt(4, model_r(4, e0, 3))) begin n_bad++; $display("FAIL d4_model: got %h want %h", bus4.sample, model_fmt(4, model_r(4, e0, 3))); end
         end
         if (n == 4*D4) begin
            n_cmp++; if (bus4.status !== 8'h07) begin n_bad++; $display("FAIL d4_overrun: status %h want 07", bus4.status); end
         end
      end
      bus4.start_rx = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      sdin  = 1'b0;
      bus8.cssdadc = 1'b0; bus8.start_rx = 1'b0; bus8.sample_ack = 1'b0;
      bus4.cssdadc = 1'b0; bus4.start_rx = 1'b0; bus4.sample_ack = 1'b0;
      test_reset();
      test_full_high();
      test_full_low();
      test_midscale();
      test_random();
      test_overrun();
      test_disable_reset();
      test_decim4();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sdadc_rx.md
# sdadc_rx

First-order sigma-delta ADC front end for the effects-pedal audio input: the capture-side counterpart to the PWM/sigma-delta DAC output. It samples the external comparator bit, drives the 1-bit feedback to the external RC integrator, and decimates the bitstream with a 2nd-order CIC into signed 24-bit samples. Samples are offered to the Wishbone wrapper through a one-entry holding register with a valid/ack handshake and an overrun flag.

## Interface

- DECIM_LOG2, 8, log2 of decimation ratio D; legal range 4..11; D = 2^DECIM_LOG2.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- sdin  in  1  comparator output, asynchronous to clk.
- cssdadc  in  1  block select from the bus wrapper.
- start_rx  in  1  capture enable; the block runs only while cssdadc && start_rx.
- sample_ack  in  1  one-cycle pulse; consumes the held sample.
- sdfb  out  1  feedback bit to the external RC network.
- sample  out  24  signed two's-complement sample.
- sample_valid  out  1  sample holds an unconsumed value.
- status  out  8  [0] running, [1] = sample_valid, [2] overrun (sticky), [7:3] = 0.

## Operation

- Synchronizer: two flops, s1 <= sdin, s2 <= s1; x = s2. The synchronizer always runs, including while the block is disabled.
- Feedback: sdfb <= s2 every enabled cycle. It is held at 0 while disabled. Polarity is non-inverted; the board network sets the loop sign.
- Width W = 2*DECIM_LOG2 + 2. All integrator and comb arithmetic is modulo 2^W; wrap is intentional.
- Integrators, updated every enabled cycle:
  - i1 <= i1 + x
  - i2 <= i2 + i1, using the old i1.
- Decimation counter: cnt counts 0..D-1 on enabled cycles and wraps. A tick occurs on the cycle where cnt == D-1.
- On a tick, the comb stage updates:
  - c1 <= i2 - d1, d1 <= i2
  - c2 <= c1new - d2, d2 <= c1new
  - Here i2 is the value before the edge, and c1new is the value of i2 - d1 computed in the same cycle.
- Raw result: r = c2, range 0..2^(2*DECIM_LOG2).
- Format stage, one cycle after the tick:
  - v = r - 2^(2*DECIM_LOG2-1)
  - Saturate v to +2^(2*DECIM_LOG2-1)-1.
  - sample = v sign-extended, then shifted left by 24-2*DECIM_LOG2.
- Warm-up: the first two tick results after each enable are discarded. A warm-up counter (0..2) gates loading of the output.
- Holding register handshake:
  - A new formatted result loads sample and sets sample_valid.
  - If sample_valid is already 1 and sample_ack is 0 on that cycle: overwrite sample and set overrun.
  - If sample_ack = 1 on the same cycle as the load: load the new sample, keep sample_valid at 1, and do not set overrun.
  - sample_ack with no load: clear sample_valid and overrun.
  - sample_ack while sample_valid = 0: no effect.
- Disable (cssdadc && start_rx falls):
  - On the next edge, clear i1, i2, d1, d2, c1, c2, cnt, the warm-up counter and the pending format stage.
  - sdfb goes to 0 and status[0] goes to 0.
  - sample, sample_valid and overrun are retained. Ack still works while disabled.
- Re-enable restarts from cnt = 0 with a full warm-up.

## Timing

- Reset values: sdfb = 0, sample = 24'h000000, sample_valid = 0, status = 8'h00. All internal registers are 0, including s1 and s2.
- Latency from sdin to x is 2 cycles. sdfb follows x one cycle later.
- With enable rising at edge E0 (first enabled cycle cnt = 0):
  - Ticks occur at enabled cycles D-1, 2D-1 and 3D-1.
  - The first sample_valid rises at edge 3D, i.e. tick + 1.
  - Subsequent samples arrive every D cycles.
- status[0] tracks the enable with one cycle of register delay.
- Reset asserted mid-operation clears everything on that edge, including a sample_valid/sample_ack pair in the same cycle.

## Test plan

- Full-scale high, DECIM_LOG2 = 8: sdin = 1 from before enable, enable at cycle 0.
  - Expect the first sample_valid at enabled cycle 768 with sample = 24'h7FFF00 (saturated).
  - Expect subsequent samples every 256 cycles.
- Full-scale low: sdin = 0.
  - Expect every valid sample = 24'h800000.
  - Expect sdfb = 0 throughout.
- Midscale: sdin alternating 1,0 every cycle.
  - After warm-up, expect sample = 24'h000000, allowing ±24'h000100 for phase.
- Overrun:
  - Never ack, constant input: the second delivered sample sets status[2] = 1 and sample_valid stays 1.
  - Pulse sample_ack: sample_valid and status[2] clear.
  - Ack in the same cycle as a load: sample_valid stays 1 and status[2] stays 0.
- Disable and reset mid-frame:
  - Drop start_rx at cnt = 100: sdfb = 0 next cycle; sample and sample_valid are retained.
  - Re-enable: the next valid sample arrives 3*256 cycles later.
  - Assert reset while sample_valid = 1: all outputs return to reset values on that edge.
- DECIM_LOG2 = 4 with sdin = 1: the first valid sample arrives at enabled cycle 48 with sample = 24'h7F0000.
